// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the MIPS multicycle main-control FSM.
// Holds the state encoding, instruction field constants, ALU operation codes,
// datapath mux-select constants and the ALU-decoder operation class.
package mips_ctrl_pkg;

  // State encoding; values are visible on a debugger and must not be reordered.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StHalt     = 4'd12
  } state_e;

  localparam logic [3:0] STATE_FETCH = 4'd0;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  // ALU A mux
  localparam logic       SRC_A_PC  = 1'b0;
  localparam logic       SRC_A_REG = 1'b1;
  // ALU B mux
  localparam logic [1:0] SRC_B_RT      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;
  // Next-PC mux
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Class of ALU operation requested by the FSM; AluFunct defers to the funct field.
  typedef enum logic [1:0] {
    AluNone  = 2'd0,
    AluAdd   = 2'd1,
    AluSub   = 2'd2,
    AluFunct = 2'd3
  } alu_op_e;

  function automatic logic is_rtype_alu(logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main-control FSM and the MIPS datapath.
// master: the controller (consumes opcode/funct/zero, drives all controls).
// slave:  the datapath side.
// With MIPS_ILLEGAL_TRAP_EN defined the bundle also carries illegal_instr.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_control;
`ifdef MIPS_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  opcode, funct, zero,
`ifdef MIPS_ILLEGAL_TRAP_EN
    output illegal_instr,
`endif
    output pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_control
  );

  modport slave (
    output opcode, funct, zero,
`ifdef MIPS_ILLEGAL_TRAP_EN
    input  illegal_instr,
`endif
    input  pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_control
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decoder.
// Ports: alu_op (operation class from the FSM), funct (R-type funct field),
//        alu_control (3-bit ALU code; 000 when no operation is requested).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      AluAdd:   alu_control = ALU_ADD;
      AluSub:   alu_control = ALU_SUB;
      AluFunct: begin
        if (funct == FN_SUB) begin
          alu_control = ALU_SUB;
        end else if (funct == FN_ADD) begin
          alu_control = ALU_ADD;
        end
      end
      default:  alu_control = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle main-control FSM for the MIPS datapath.
// Ports: clk (rising edge), reset (synchronous, active-high),
//        bus (mips_multicycle_control_if.master: opcode/funct/zero in, controls out).
// Parameter RESET_STATE selects the state entered on reset (FETCH for normal use).
// Optional macro MIPS_ILLEGAL_TRAP_EN: illegal instructions enter HALT and raise
// illegal_instr until reset; otherwise they retire as a two-cycle NOP.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = STATE_FETCH
) (
  input logic                      clk,
  input logic                      reset,
  mips_multicycle_control_if.master bus
);

  state_e state_q, state_d;

  logic       pc_write;
  logic       pc_write_cond_raw;
  logic       i_or_d_raw;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       mem_to_reg_raw;
  logic       reg_dst_raw;
  logic       reg_write_raw;
  logic       alu_src_a_raw;
  logic [1:0] alu_src_b_raw;
  logic [1:0] pc_source_raw;
  logic       illegal_raw;
  alu_op_e    alu_op;
  logic [2:0] alu_control_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = StFetch;
    pc_write          = 1'b0;
    pc_write_cond_raw = 1'b0;
    i_or_d_raw        = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    mem_to_reg_raw    = 1'b0;
    reg_dst_raw       = 1'b0;
    reg_write_raw     = 1'b0;
    alu_src_a_raw     = SRC_A_PC;
    alu_src_b_raw     = SRC_B_RT;
    pc_source_raw     = PC_SRC_ALU;
    illegal_raw       = 1'b0;
    alu_op            = AluNone;

    case (state_q)
      StFetch: begin
        mem_read_raw  = 1'b1;
        ir_write_raw  = 1'b1;
        pc_write      = 1'b1;
        alu_src_b_raw = SRC_B_FOUR;
        alu_op        = AluAdd;
        state_d       = StDecode;
      end
      StDecode: begin
        // Speculative branch target into ALUOut
        alu_src_b_raw = SRC_B_IMM_SH2;
        alu_op        = AluAdd;
        if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
          state_d = StMemAddr;
        end else if ((bus.opcode == OP_RTYPE) && is_rtype_alu(bus.funct)) begin
          state_d = StExecute;
        end else if (bus.opcode == OP_BEQ) begin
          state_d = StBranch;
        end else if (bus.opcode == OP_J) begin
          state_d = StJump;
        end else if (bus.opcode == OP_ADDI) begin
          state_d = StAddiExec;
        end else begin
`ifdef MIPS_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StFetch;
`endif
        end
      end
      StMemAddr: begin
        alu_src_a_raw = SRC_A_REG;
        alu_src_b_raw = SRC_B_IMM;
        alu_op        = AluAdd;
        state_d       = (bus.opcode == OP_LW) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_read_raw = 1'b1;
        i_or_d_raw   = 1'b1;
        state_d      = StMemWb;
      end
      StMemWb: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
        state_d        = StFetch;
      end
      StMemWrite: begin
        mem_write_raw = 1'b1;
        i_or_d_raw    = 1'b1;
        state_d       = StFetch;
      end
      StExecute: begin
        alu_src_a_raw = SRC_A_REG;
        alu_src_b_raw = SRC_B_RT;
        alu_op        = AluFunct;
        state_d       = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        reg_dst_raw   = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        alu_src_a_raw     = SRC_A_REG;
        alu_src_b_raw     = SRC_B_RT;
        alu_op            = AluSub;
        pc_write_cond_raw = 1'b1;
        pc_source_raw     = PC_SRC_ALUOUT;
        state_d           = StFetch;
      end
      StJump: begin
        pc_write      = 1'b1;
        pc_source_raw = PC_SRC_JUMP;
        state_d       = StFetch;
      end
      StAddiExec: begin
        alu_src_a_raw = SRC_A_REG;
        alu_src_b_raw = SRC_B_IMM;
        alu_op        = AluAdd;
        state_d       = StAddiWb;
      end
      StAddiWb: begin
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
`ifdef MIPS_ILLEGAL_TRAP_EN
      StHalt: begin
        illegal_raw = 1'b1;
        state_d     = StHalt;
      end
`endif
      // Unused encodings: all outputs idle, recover to FETCH
      default: state_d = StFetch;
    endcase
  end

  mips_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.funct),
    .alu_control (alu_control_raw)
  );

  // Every output is held at zero while reset is asserted
  assign bus.pc_en         = ~reset & (pc_write | (pc_write_cond_raw & bus.zero));
  assign bus.pc_write_cond = ~reset & pc_write_cond_raw;
  assign bus.i_or_d        = ~reset & i_or_d_raw;
  assign bus.mem_read      = ~reset & mem_read_raw;
  assign bus.mem_write     = ~reset & mem_write_raw;
  assign bus.ir_write      = ~reset & ir_write_raw;
  assign bus.mem_to_reg    = ~reset & mem_to_reg_raw;
  assign bus.reg_dst       = ~reset & reg_dst_raw;
  assign bus.reg_write     = ~reset & reg_write_raw;
  assign bus.alu_src_a     = ~reset & alu_src_a_raw;
  assign bus.alu_src_b     = reset ? 2'b00 : alu_src_b_raw;
  assign bus.pc_source     = reset ? 2'b00 : pc_source_raw;
  assign bus.alu_control   = reset ? 3'b000 : alu_control_raw;
`ifdef MIPS_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = ~reset & illegal_raw;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_raw;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Testbench for mips_multicycle_control: an instruction-level model (kind of
// instruction plus cycle index within it) predicts every output on every cycle,
// and directed literal checks pin key values and per-instruction latencies.
module tb_mips_multicycle_control;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   m_step;
  logic chk_en;

  mips_multicycle_control_if bus ();

  mips_multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int KLw = 0, KSw = 1, KRadd = 2, KRsub = 3, KBeq = 4, KJ = 5, KAddi = 6, KIll = 7;

`ifdef MIPS_ILLEGAL_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b100011) return KLw;
    if (op == 6'b101011) return KSw;
    if (op == 6'b000000 && fn == 6'b100000) return KRadd;
    if (op == 6'b000000 && fn == 6'b100010) return KRsub;
    if (op == 6'b000100) return KBeq;
    if (op == 6'b000010) return KJ;
    if (op == 6'b001000) return KAddi;
    return KIll;
  endfunction

  function automatic int latency(int k);
    case (k)
      KLw:                  return 5;
      KSw, KRadd, KRsub:    return 4;
      KAddi:                return 4;
      KBeq, KJ:             return 3;
      default:              return 2;
    endcase
  endfunction

  // Expected outputs packed as
  // {illegal, pc_en, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_control}
  function automatic logic [17:0] model_out(int k, int s, logic z, logic r);
    logic pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    if (!r) begin
      if (s == 0) begin
        mr = 1; irw = 1; pe = 1; sb = 2'b01; alu = 3'b010;
      end else if (s == 1) begin
        sb = 2'b11; alu = 3'b010;
      end else begin
        case (k)
          KLw, KSw: begin
            if (s == 2) begin sa = 1; sb = 2'b10; alu = 3'b010; end
            else if (s == 3 && k == KLw) begin mr = 1; iod = 1; end
            else if (s == 3) begin mw = 1; iod = 1; end
            else if (s == 4) begin rw = 1; m2r = 1; end
          end
          KRadd, KRsub: begin
            if (s == 2) begin sa = 1; alu = (k == KRsub) ? 3'b110 : 3'b010; end
            else begin rw = 1; rd = 1; end
          end
          KBeq: begin sa = 1; alu = 3'b110; pwc = 1; ps = 2'b01; pe = z; end
          KJ:   begin pe = 1; ps = 2'b10; end
          KAddi: begin
            if (s == 2) begin sa = 1; sb = 2'b10; alu = 3'b010; end
            else rw = 1;
          end
          default: ill = Trap;
        endcase
      end
    end
    return {ill, pe, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ps, alu};
  endfunction

  logic [17:0] act;
  logic        ill_act;
`ifdef MIPS_ILLEGAL_TRAP_EN
  assign ill_act = bus.illegal_instr;
`else
  assign ill_act = 1'b0;
`endif
  assign act = {ill_act, bus.pc_en, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.pc_source, bus.alu_control};

  // Model advance: position within the current instruction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_step <= 0;
    end else if (Trap && classify(bus.opcode, bus.funct) == KIll && m_step >= 1) begin
      m_step <= 2;
    end else if (m_step + 1 >= latency(classify(bus.opcode, bus.funct))) begin
      m_step <= 0;
    end else begin
      m_step <= m_step + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [17:0] exp_v;
    if (chk_en) begin
      exp_v = model_out(classify(bus.opcode, bus.funct), m_step, bus.zero, reset);
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t step=%0d op=%b fn=%b actual=%b required=%b",
                 $time, m_step, bus.opcode, bus.funct, act, exp_v);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic wait_step(input int n);
    bit hit;
    hit = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (m_step == n) begin
        hit = 1;
        break;
      end
    end
    check_lit("wait_step_reached", {7'd0, hit}, 8'd1);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int exp_lat, input string name);
    int start;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    start = cyc;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (m_step == 0) break;
    end
    check_lit(name, 8'(cyc - start), 8'(exp_lat));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; m_step = 0; chk_en = 0;
    reset = 1'b1;
    bus.opcode = 6'b000000; bus.funct = 6'b000000; bus.zero = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    reset = 1'b0;

    // FETCH right after reset
    @(negedge clk);
    check_lit("fetch_mem_read", {7'd0, bus.mem_read}, 8'd1);
    check_lit("fetch_ir_write", {7'd0, bus.ir_write}, 8'd1);
    check_lit("fetch_pc_en", {7'd0, bus.pc_en}, 8'd1);
    check_lit("fetch_alu_control", {5'd0, bus.alu_control}, 8'b010);
    check_lit("fetch_reg_write", {7'd0, bus.reg_write}, 8'd0);

    // lw walk-through
    bus.opcode = 6'b100011; bus.funct = 6'b000000;
    wait_step(2);
    @(negedge clk);
    check_lit("lw_memaddr_alu_src_b", {6'd0, bus.alu_src_b}, 8'b10);
    wait_step(4);
    @(negedge clk);
    check_lit("lw_wb_reg_write", {7'd0, bus.reg_write}, 8'd1);
    check_lit("lw_wb_mem_to_reg", {7'd0, bus.mem_to_reg}, 8'd1);
    wait_step(0);

    // R-type sub
    bus.opcode = 6'b000000; bus.funct = 6'b100010;
    wait_step(2);
    @(negedge clk);
    check_lit("sub_exec_alu_control", {5'd0, bus.alu_control}, 8'b110);
    wait_step(3);
    @(negedge clk);
    check_lit("sub_wb_reg_dst", {7'd0, bus.reg_dst}, 8'd1);
    wait_step(0);

    run_instr(6'b100011, 6'b000000, 1'b0, 5, "lat_lw");
    run_instr(6'b000000, 6'b100000, 1'b0, 4, "lat_add");
    run_instr(6'b101011, 6'b000000, 1'b1, 4, "lat_sw");
    run_instr(6'b001000, 6'b111111, 1'b0, 4, "lat_addi");
    run_instr(6'b000010, 6'b000000, 1'b1, 3, "lat_j");

    // beq taken / not taken
    bus.opcode = 6'b000100; bus.zero = 1'b1;
    wait_step(2);
    @(negedge clk);
    check_lit("beq_taken_pc_en", {7'd0, bus.pc_en}, 8'd1);
    check_lit("beq_pc_source", {6'd0, bus.pc_source}, 8'b01);
    wait_step(0);
    run_instr(6'b000100, 6'b000000, 1'b0, 3, "lat_beq_nt");
    bus.opcode = 6'b000100; bus.zero = 1'b0;
    wait_step(2);
    @(negedge clk);
    check_lit("beq_not_taken_pc_en", {7'd0, bus.pc_en}, 8'd0);
    wait_step(0);

    // Reset in MEM_READ
    bus.opcode = 6'b100011;
    wait_step(3);
    reset = 1'b1;
    @(negedge clk);
    check_lit("reset_mem_read", {7'd0, bus.mem_read}, 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_lit("after_reset_ir_write", {7'd0, bus.ir_write}, 8'd1);
    wait_step(0);

`ifdef MIPS_ILLEGAL_TRAP_EN
    bus.opcode = 6'b111111; bus.funct = 6'b000000;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_lit("halt_illegal_instr", {7'd0, bus.illegal_instr}, 8'd1);
    check_lit("halt_mem_read", {7'd0, bus.mem_read}, 8'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    check_lit("reset_clears_illegal", {7'd0, bus.illegal_instr}, 8'd0);
    @(posedge clk); #1;
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    reset = 1'b0;
    @(negedge clk);
    check_lit("halt_exit_fetch", {7'd0, bus.mem_read}, 8'd1);
    wait_step(0);
`else
    run_instr(6'b111111, 6'b000000, 1'b0, 2, "lat_illegal_op");
    run_instr(6'b000000, 6'b100100, 1'b0, 2, "lat_illegal_funct");
`endif
    run_instr(6'b000000, 6'b100000, 1'b0, 4, "lat_add_final");

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
